// File: rtl/pkt_arb_pkg.sv
// Shared types for the packet push arbiter: packet record, FSM states, queue depth.
package pkt_arb_pkg;

  typedef struct packed {
    int         id;
    bit [127:0] src;
    bit [127:0] dest;
    bit [127:0] payload;
  } pkt_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int QUEUE_DEPTH = 1024;

endpackage

// File: rtl/pkt_push_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Finds the first set request bit
// at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  // Scan from the farthest rotation back to ptr so the closest request wins.
  always_comb begin
    int j;
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pkt_push_arbiter.sv
// pkt_push_arbiter: round-robin sharing of one queue push port among NUM_REQ
// valid/ready producers, with bursts capped at BURST_MAX packets per grant.
// The push is combinational from the winning producer (no data register) and
// is suppressed entirely while the queue reports full.
// Optional feature macro: ARB_STATS_EN builds saturating per-producer transfer
// counters readable through stat_sel/stat_cnt; otherwise stat_cnt is 0.
module pkt_push_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BURST_MAX = 8,
  parameter int IW        = $clog2(NUM_REQ),
  parameter int BW        = $clog2(BURST_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  pkt_t [NUM_REQ-1:0]   req_pkt,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 q_full,
  output logic                 q_push,
  output pkt_t                 q_pkt,
  output logic [IW-1:0]        grant_idx,
  output logic                 busy,
  input  logic [IW-1:0]        stat_sel,
  output logic [31:0]          stat_cnt
);

  arb_state_e    state, state_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic [IW-1:0] grant_nxt;

  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] sel;
  logic          xfer;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] x);
    return (int'(x) == NUM_REQ - 1) ? '0 : IW'(int'(x) + 1);
  endfunction

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // State register: FSM state, round-robin pointer, burst owner/count, grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      bcnt      <= '0;
      grant_idx <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      bcnt      <= bcnt_nxt;
      grant_idx <= grant_nxt;
    end
  end

  // Next-state: everything only moves on a transfer, so q_full freezes it all.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    bcnt_nxt   = bcnt;
    grant_nxt  = grant_idx;
    if (xfer) begin
      grant_nxt = sel;
      if (state == IDLE) begin
        if (BURST_MAX == 1 || req_last[sel]) begin
          rr_ptr_nxt = inc_wrap(sel);
        end else begin
          state_nxt = LOCK;
          owner_nxt = sel;
          bcnt_nxt  = BW'(1);
        end
      end else begin
        bcnt_nxt = bcnt + BW'(1);
        if (req_last[sel] || (int'(bcnt) + 1 == BURST_MAX)) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = inc_wrap(owner);
          bcnt_nxt   = '0;
        end
      end
    end
  end

  // Outputs: one-hot ready to the winner/owner, same-cycle push of its packet.
  always_comb begin
    req_ready = '0;
    sel       = (state == LOCK) ? owner : pick_idx;
    if (rst_n && !q_full) begin
      if (state == LOCK) begin
        req_ready[owner] = 1'b1;
      end else if (pick_any) begin
        req_ready[pick_idx] = 1'b1;
      end
    end
    xfer   = req_valid[sel] & req_ready[sel];
    q_push = xfer;
    q_pkt  = xfer ? req_pkt[sel] : '0;
    busy   = (state == LOCK);
  end

`ifdef ARB_STATS_EN
  logic [31:0] cnt [NUM_REQ];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Per-producer transfer counters, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (xfer) begin
      cnt[sel] <= sat_inc(cnt[sel]);
    end
  end

  assign stat_cnt = cnt[stat_sel];
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_pkt_push_arbiter.sv
// Directed bench for pkt_push_arbiter (NUM_REQ=4, BURST_MAX=4): a cycle table
// of inputs and expected outputs, plus hand sequences for reset and stats.
module tb_pkt_push_arbiter;
  import pkt_arb_pkg::*;

  localparam int N  = 4;
  localparam int BM = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  pkt_t [N-1:0]   req_pkt;
  logic [N-1:0]   req_ready;
  logic           q_full = 1'b0;
  logic           q_push;
  pkt_t           q_pkt;
  logic [1:0]     grant_idx;
  logic           busy;
  logic [1:0]     stat_sel = '0;
  logic [31:0]    stat_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pkt_push_arbiter #(.NUM_REQ(N), .BURST_MAX(BM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_pkt   (req_pkt),
    .req_ready (req_ready),
    .q_full    (q_full),
    .q_push    (q_push),
    .q_pkt     (q_pkt),
    .grant_idx (grant_idx),
    .busy      (busy),
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt)
  );

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       f;
    logic [3:0] rdy;
    logic       push;
    int         id;
    logic       bsy;
    logic [1:0] gnt;
  } vec_t;

  vec_t vt[$];

  function automatic pkt_t mk_pkt(int i);
    pkt_t p;
    p.id      = i;
    p.src     = {4{32'h5000_0000 + 32'(i)}};
    p.dest    = {4{32'hD000_0000 + 32'(i)}};
    p.payload = {4{32'hA5A5_0000 + 32'(i)}};
    return p;
  endfunction

  function automatic vec_t mkv(logic [3:0] v, logic [3:0] l, logic f, logic [3:0] rdy,
                               logic push, int id, logic bsy, logic [1:0] gnt);
    vec_t r;
    r.v = v; r.l = l; r.f = f; r.rdy = rdy; r.push = push; r.id = id; r.bsy = bsy; r.gnt = gnt;
    return r;
  endfunction

  task automatic chk(string nm, logic [415:0] act, logic [415:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outputs(string tag, logic [3:0] rdy, logic push, int id, logic bsy, logic [1:0] gnt);
    pkt_t ep;
    ep = push ? mk_pkt(id) : '0;
    chk({tag, "_ready"}, 416'(req_ready), 416'(rdy));
    chk({tag, "_push"},  416'(q_push),    416'(push));
    chk({tag, "_pkt"},   q_pkt,           ep);
    chk({tag, "_busy"},  416'(busy),      416'(bsy));
    chk({tag, "_grant"}, 416'(grant_idx), 416'(gnt));
  endtask

  task automatic drive(logic [3:0] v, logic [3:0] l, logic f);
    @(negedge clk);
    req_valid = v;
    req_last  = l;
    q_full    = f;
    #2;
  endtask

  initial begin
    logic [31:0] exp_s2, exp_s0;
    for (int i = 0; i < N; i++) req_pkt[i] = mk_pkt(i);

    // round-robin with single-packet offers, wrap to P0
    vt.push_back(mkv(4'b1111, 4'b1111, 0, 4'b0001, 1, 0, 0, 2'd0));
    vt.push_back(mkv(4'b1111, 4'b1111, 0, 4'b0010, 1, 1, 0, 2'd0));
    vt.push_back(mkv(4'b1111, 4'b1111, 0, 4'b0100, 1, 2, 0, 2'd1));
    vt.push_back(mkv(4'b1111, 4'b1111, 0, 4'b1000, 1, 3, 0, 2'd2));
    vt.push_back(mkv(4'b1111, 4'b1111, 0, 4'b0001, 1, 0, 0, 2'd3));
    // P1 three-packet burst while P0/P2 wait, then P2
    vt.push_back(mkv(4'b0111, 4'b0000, 0, 4'b0010, 1, 1, 0, 2'd0));
    vt.push_back(mkv(4'b0111, 4'b0000, 0, 4'b0010, 1, 1, 1, 2'd1));
    vt.push_back(mkv(4'b0111, 4'b0010, 0, 4'b0010, 1, 1, 1, 2'd1));
    vt.push_back(mkv(4'b0111, 4'b0111, 0, 4'b0100, 1, 2, 0, 2'd1));
    // P0 six packets, forced release after four, P1, then P0 resumes
    vt.push_back(mkv(4'b0011, 4'b0000, 0, 4'b0001, 1, 0, 0, 2'd2));
    vt.push_back(mkv(4'b0011, 4'b0000, 0, 4'b0001, 1, 0, 1, 2'd0));
    vt.push_back(mkv(4'b0011, 4'b0000, 0, 4'b0001, 1, 0, 1, 2'd0));
    vt.push_back(mkv(4'b0011, 4'b0000, 0, 4'b0001, 1, 0, 1, 2'd0));
    vt.push_back(mkv(4'b0011, 4'b0010, 0, 4'b0010, 1, 1, 0, 2'd0));
    vt.push_back(mkv(4'b0011, 4'b0000, 0, 4'b0001, 1, 0, 0, 2'd1));
    vt.push_back(mkv(4'b0001, 4'b0001, 0, 4'b0001, 1, 0, 1, 2'd0));
    // P3 burst stalled three cycles by q_full, owner drops valid once
    vt.push_back(mkv(4'b1000, 4'b0000, 0, 4'b1000, 1, 3, 0, 2'd0));
    vt.push_back(mkv(4'b1000, 4'b0000, 1, 4'b0000, 0, 0, 1, 2'd3));
    vt.push_back(mkv(4'b1000, 4'b0000, 1, 4'b0000, 0, 0, 1, 2'd3));
    vt.push_back(mkv(4'b1000, 4'b0000, 1, 4'b0000, 0, 0, 1, 2'd3));
    vt.push_back(mkv(4'b1000, 4'b0000, 0, 4'b1000, 1, 3, 1, 2'd3));
    vt.push_back(mkv(4'b0111, 4'b0000, 0, 4'b1000, 0, 0, 1, 2'd3));
    vt.push_back(mkv(4'b1000, 4'b1000, 0, 4'b1000, 1, 3, 1, 2'd3));
    // q_full in IDLE holds the pointer; idle with nothing valid
    vt.push_back(mkv(4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 2'd3));
    vt.push_back(mkv(4'b1111, 4'b1111, 0, 4'b0001, 1, 0, 0, 2'd3));
    vt.push_back(mkv(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 2'd0));

    // reset state, asserted and just released
    repeat (2) @(posedge clk);
    #2;
    chk_outputs("in_reset", 4'b0000, 0, 0, 0, 2'd0);
    chk("in_reset_stat", 416'(stat_cnt), 416'(0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 4'b0000, 0);
    chk_outputs("post_reset", 4'b0000, 0, 0, 0, 2'd0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].v, vt[i].l, vt[i].f);
      chk_outputs($sformatf("vec%0d", i), vt[i].rdy, vt[i].push, vt[i].id, vt[i].bsy, vt[i].gnt);
    end

    // reset mid-burst of P2 (pointer is 1 here)
    drive(4'b0100, 4'b0000, 0);
    chk_outputs("rst_b0", 4'b0100, 1, 2, 0, 2'd0);
    drive(4'b0100, 4'b0000, 0);
    chk_outputs("rst_b1", 4'b0100, 1, 2, 1, 2'd2);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    #2;
    chk_outputs("rst_asserted", 4'b0000, 0, 0, 0, 2'd0);
    repeat (2) @(negedge clk);
    #2;
    chk_outputs("rst_held", 4'b0000, 0, 0, 0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk_outputs("rst_release", 4'b0001, 1, 0, 0, 2'd0);

    // five P2 transfers, then read the counters
    for (int k = 0; k < 5; k++) begin
      drive(4'b0100, 4'b0100, 0);
      chk_outputs($sformatf("p2x%0d", k), 4'b0100, 1, 2, 0, (k == 0) ? 2'd0 : 2'd2);
    end
    drive(4'b0000, 4'b0000, 0);
`ifdef ARB_STATS_EN
    exp_s2 = 32'd5;
    exp_s0 = 32'd1;
`else
    exp_s2 = 32'd0;
    exp_s0 = 32'd0;
`endif
    stat_sel = 2'd2;
    #1;
    chk("stat_p2", 416'(stat_cnt), 416'(exp_s2));
    stat_sel = 2'd0;
    #1;
    chk("stat_p0", 416'(stat_cnt), 416'(exp_s0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
